serial_adder: RTL
=================

# serial_adder

Parametrised digit-serial two's-complement adder/subtractor: the multi-cycle successor to the team's 4-bit combinational adder. It consumes two WIDTH-bit operands after a start pulse, processes DIGIT bits per clock, and returns sum/difference, carry-out and signed overflow with a busy/done handshake. It sits between the lab's operand registers and the result display/check logic, trading latency for a narrow adder datapath.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH; N = WIDTH/DIGIT cycles per operation
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  launch request, sampled on rising clk
- sub  input  1  0 = in1+in2, 1 = in1−in2; sampled with start
- in1  input  WIDTH  operand A, sampled with start
- in2  input  WIDTH  operand B, sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: results just updated
- out1  output  WIDTH  sum/difference, held until next completion
- cout  output  1  carry out of MSB; for sub, 1 = no borrow
- ovf  output  1  signed two's-complement overflow

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. On start=1: latch A=in1, B=(sub ? ~in2 : in2), carry=sub, digit counter=0 → RUN.
- RUN: busy=1. Each cycle adds A[DIGIT-1:0]+B[DIGIT-1:0]+carry; shifts the digit sum into the top of a result shift register; shifts A and B right by DIGIT; updates carry; counter++. After digit N−1 → DONE.
- On the last digit, ovf = (A_msb == B_msb) && (sum_msb != A_msb) using the effective (possibly inverted) B.
- Entering DONE: out1, cout, ovf load from the shift register and the final carry/ovf; these outputs change at no other time.
- DONE: done=1, busy=0 for exactly one cycle. start=1 in DONE launches the next operation immediately (→ RUN with new operands); otherwise → IDLE.
- start during RUN is ignored; in1/in2/sub may change freely after sampling.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Reset values: busy=0, done=0, out1=0, cout=0, ovf=0, state=IDLE, internal registers 0.
- start sampled at edge k → busy=1 for cycles after edges k..k+N−1 → done=1 in the cycle after edge k+N; latency N+1 edges.
- Back-to-back throughput: one result per N+1 cycles.
- DIGIT=WIDTH: N=1, done in the cycle after edge k+1.
- rst=1 at any edge (including mid-RUN or in DONE) returns to IDLE with all outputs at reset values; the aborted operation yields no done. rst overrides a simultaneous start.

## Structure
- Package adder_pkg: FSM state encoding (IDLE/RUN/DONE localparams) and the counter-width function clog2.
- One sub-module: digit_add — combinational DIGIT-bit ripple adder (a, b, cin → s, cout, plus carry into MSB for overflow), instantiated once in the datapath.
- Top: FSM, digit counter, A/B shift registers, result shift register, output registers.

## Test plan
(WIDTH=16, DIGIT=4 unless noted)
- Add 0x0009+0x0006, sub=0 → done in cycle after edge k+4; out1=0x000F, cout=0, ovf=0; busy high for 4 cycles.
- Add 0x7FFF+0x0001 → out1=0x8000, cout=0, ovf=1; add 0xFFFF+0x0001 → out1=0x0000, cout=1, ovf=0.
- Sub 0x0003−0x000F → out1=0xFFF4, cout=0, ovf=0; sub 0x8000−0x0001 → out1=0x7FFF, cout=1, ovf=1.
- Hold start=1 continuously with operands changing mid-RUN → only values sampled at IDLE/DONE edges used; done pulses every 5 cycles; results unaffected by mid-RUN changes.
- Assert rst two cycles into RUN → next cycle busy=0, done=0, out1=0; no done pulse follows; a fresh start then completes normally.
- WIDTH=8, DIGIT=8: 0x99+0x66 → out1=0xFF, done in cycle after edge k+1; WIDTH=8, DIGIT=1: same operands → done after edge k+8.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and a
// constant-evaluable ceiling log2 used to size the digit counter.
package adder_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

   // Number of bits needed to count 0..value-1 (0 when value <= 1).
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/digit_add.sv
// Combinational DIGIT-bit ripple-carry adder. Besides the sum and carry-out it
// exposes the carry into the MSB so the caller can derive signed overflow.
module digit_add #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] i_a,
   input  logic [DIGIT-1:0] i_b,
   input  logic             i_cin,
   output logic [DIGIT-1:0] o_s,
   output logic             o_cout,
   output logic             o_cmsb
);

   // Ripple the carry LSB to MSB, capturing the carry entering the top bit.
   always_comb begin : ripple
      logic c;
      c      = i_cin;
      o_s    = '0;
      o_cmsb = 1'b0;
      for (int i = 0; i < DIGIT; i++) begin
         o_s[i] = i_a[i] ^ i_b[i] ^ c;
         if (i == DIGIT - 1) begin
            o_cmsb = c;
         end
         c = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
      end
      o_cout = c;
   end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial two's-complement adder/subtractor. Operands are captured on a
// start pulse, DIGIT bits are summed per clock through a narrow ripple adder,
// and the full result plus carry-out and signed overflow are presented with a
// one-cycle done pulse after WIDTH/DIGIT processing cycles.
module serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out1,
   output logic             cout,
   output logic             ovf
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

   state_t           r_state;
   state_t           w_next;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;

   logic [WIDTH-1:0] w_res_next;
   logic [DIGIT-1:0] w_sum;
   logic             w_cout;
   logic             w_cmsb;
   logic             w_load;
   logic             w_step;
   logic             w_last;

   // A new operation may be accepted whenever the engine is not mid-run,
   // which lets a start in the DONE cycle chain straight into the next job.
   assign w_load = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_step = (r_state == RUN);
   assign w_last = w_step && (r_cnt == LAST_CNT);

   assign busy = (r_state == RUN);
   assign done = (r_state == DONE);

   digit_add #(
      .DIGIT (DIGIT)
   ) u_digit_add (
      .i_a    (r_a[DIGIT-1:0]),
      .i_b    (r_b[DIGIT-1:0]),
      .i_cin  (r_carry),
      .o_s    (w_sum),
      .o_cout (w_cout),
      .o_cmsb (w_cmsb)
   );

   // The newest digit enters at the top, so after N shifts the first digit
   // has reached the LSB position and the register holds the whole result.
   generate
      if (DIGIT == WIDTH) begin : g_res_single
         assign w_res_next = w_sum;
      end else begin : g_res_shift
         assign w_res_next = {w_sum, r_res[WIDTH-1:DIGIT]};
      end
   endgenerate

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic: IDLE waits for start, RUN counts digits, DONE lasts
   // one cycle and either relaunches or falls back to IDLE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next = RUN;
            end
         end
         RUN: begin
            if (w_last) begin
               w_next = DONE;
            end
         end
         DONE: begin
            if (start) begin
               w_next = RUN;
            end else begin
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Operand/carry capture and per-digit shifting. Subtraction is performed
   // as A + ~B + 1, with the +1 supplied as the initial carry.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else if (w_load) begin
         r_a     <= in1;
         r_b     <= sub ? ~in2 : in2;
         r_carry <= sub;
         r_cnt   <= '0;
      end else if (w_step) begin
         r_a     <= r_a >> DIGIT;
         r_b     <= r_b >> DIGIT;
         r_res   <= w_res_next;
         r_carry <= w_cout;
         r_cnt   <= r_cnt + CNT_W'(1);
      end
   end

   // Result registers update only when the final digit is processed, so they
   // hold the last completed result through IDLE and any following run.
   // Overflow is carry-in-to-MSB XOR carry-out, equivalent to operands of
   // equal sign producing a sum of the opposite sign.
   always_ff @(posedge clk) begin
      if (rst) begin
         out1 <= '0;
         cout <= 1'b0;
         ovf  <= 1'b0;
      end else if (w_last) begin
         out1 <= w_res_next;
         cout <= w_cout;
         ovf  <= w_cmsb ^ w_cout;
      end
   end

endmodule
